// File: rtl/seq_fsm_pkg.sv
// -----------------------------------------------------------------------------
// seq_fsm_pkg
// Shared definitions for the serial pattern link: one-hot frame-state encoding,
// the default sync preamble (also used by the downstream detector) and a small
// width helper.
// -----------------------------------------------------------------------------
package seq_fsm_pkg;

    // Default sync preamble, sent MSB first.
    localparam int unsigned           PRE_W_DEF    = 4;
    localparam logic [PRE_W_DEF-1:0]  PREAMBLE_DEF = 4'b1010;

    // One-hot frame states.
    localparam int unsigned     ST_W    = 4;
    localparam logic [ST_W-1:0] ST_IDLE = 4'b0001;
    localparam logic [ST_W-1:0] ST_PRE  = 4'b0010;
    localparam logic [ST_W-1:0] ST_DATA = 4'b0100;
    localparam logic [ST_W-1:0] ST_GAP  = 4'b1000;

    typedef enum logic [ST_W-1:0] {
        S_IDLE = ST_IDLE,
        S_PRE  = ST_PRE,
        S_DATA = ST_DATA,
        S_GAP  = ST_GAP
    } frame_state_t;

    // Largest of three values; sizes the shared bit counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// -----------------------------------------------------------------------------
// seq_frame_tx_if
// Upstream word handover for the frame transmitter (valid/ready handshake).
//   tx_data  : payload word, held by upstream until accepted
//   tx_valid : upstream has a word
//   tx_ready : transmitter can accept; accept = tx_valid & tx_ready at clk edge
// Modports: master = upstream word source, slave = transmitter.
// -----------------------------------------------------------------------------
interface seq_frame_tx_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/seq_bit_timer.sv
// -----------------------------------------------------------------------------
// seq_bit_timer
// Divides clk into serial bit periods of BIT_DIV cycles.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears the divider
//   i_idle     : transmitter idle, holds the divider cleared
//   i_start    : restart the divider at the first bit of a frame
//   o_bit_tick : high on the last clk cycle of each bit (constant 1 if BIT_DIV=1)
// -----------------------------------------------------------------------------
module seq_bit_timer #(
    parameter int unsigned BIT_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_idle,
    input  logic i_start,
    output logic o_bit_tick
);

    localparam int unsigned CNT_W = $clog2(BIT_DIV + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last     = (r_cnt == CNT_W'(BIT_DIV - 1));
    assign o_bit_tick = (BIT_DIV == 1) ? 1'b1 : w_last;

    // Cycle-within-bit counter; wraps on the last cycle of each bit.
    always_ff @(posedge clk) begin
        if (rst || i_idle || i_start) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_frame_tx.sv
// -----------------------------------------------------------------------------
// seq_frame_tx
// Serializes one parallel word per frame: PRE_W preamble bits, DATA_W payload
// bits MSB first, then GAP_BITS zero bits. Each bit lasts BIT_DIV clk cycles.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   tx           : slave side of the word handshake (tx_data/tx_valid/tx_ready)
//   o_dout       : serial line to the detector din; idles low
//   o_dout_en    : strobe on the first cycle of each preamble/data bit
//   o_busy       : frame in progress
//   o_frame_done : one-cycle pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module seq_frame_tx
    import seq_fsm_pkg::*;
#(
    parameter int unsigned         DATA_W   = 8,
    parameter int unsigned         PRE_W    = PRE_W_DEF,
    parameter logic [PRE_W-1:0]    PREAMBLE = PRE_W'(PREAMBLE_DEF),
    parameter int unsigned         GAP_BITS = 2,
    parameter int unsigned         BIT_DIV  = 1
) (
    input  logic               clk,
    input  logic               rst,
    seq_frame_tx_if.slave      tx,
    output logic               o_dout,
    output logic               o_dout_en,
    output logic               o_busy,
    output logic               o_frame_done
);

    localparam int unsigned BCNT_W = $clog2(max3(PRE_W, DATA_W, GAP_BITS) + 1);

    frame_state_t      r_state;
    frame_state_t      w_state_nxt;

    logic              r_dout;
    logic              r_dout_en;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_ready;
    logic [BCNT_W-1:0] r_bcnt;
    logic [PRE_W-1:0]  r_pre;
    logic [DATA_W-1:0] r_shift;

    logic              w_dout_nxt;
    logic              w_dout_en_nxt;
    logic              w_busy_nxt;
    logic              w_frame_done_nxt;
    logic              w_ready_nxt;
    logic [BCNT_W-1:0] w_bcnt_nxt;
    logic [PRE_W-1:0]  w_pre_nxt;
    logic [DATA_W-1:0] w_shift_nxt;

    logic              w_accept;
    logic              w_bit_tick;
    logic              w_idle;

    assign w_accept = tx.tx_valid & r_ready;
    assign w_idle   = (r_state == S_IDLE);

    seq_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .i_idle     (w_idle),
        .i_start    (w_accept),
        .o_bit_tick (w_bit_tick)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dout       <= 1'b0;
            r_dout_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_ready      <= 1'b1;
            r_bcnt       <= '0;
            r_pre        <= '0;
            r_shift      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_en    <= w_dout_en_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_ready      <= w_ready_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_pre        <= w_pre_nxt;
            r_shift      <= w_shift_nxt;
        end
    end

    // Next state and next output values. r_bcnt holds the bits still to come
    // after the one currently on the line, so a phase ends when it reads 0.
    always_comb begin
        w_state_nxt      = r_state;
        w_dout_nxt       = r_dout;
        w_dout_en_nxt    = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_bcnt_nxt       = r_bcnt;
        w_pre_nxt        = r_pre;
        w_shift_nxt      = r_shift;

        unique case (r_state)
            S_IDLE: begin
                w_dout_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt   = S_PRE;
                    w_dout_nxt    = PREAMBLE[PRE_W-1];
                    w_dout_en_nxt = 1'b1;
                    w_pre_nxt     = PREAMBLE << 1;
                    w_shift_nxt   = tx.tx_data;
                    w_bcnt_nxt    = BCNT_W'(PRE_W - 1);
                end
            end

            S_PRE: begin
                if (w_bit_tick) begin
                    w_dout_en_nxt = 1'b1;
                    if (r_bcnt == '0) begin
                        w_state_nxt = S_DATA;
                        w_dout_nxt  = r_shift[DATA_W-1];
                        w_shift_nxt = r_shift << 1;
                        w_bcnt_nxt  = BCNT_W'(DATA_W - 1);
                    end else begin
                        w_dout_nxt = r_pre[PRE_W-1];
                        w_pre_nxt  = r_pre << 1;
                        w_bcnt_nxt = r_bcnt - BCNT_W'(1);
                    end
                end
            end

            S_DATA: begin
                if (w_bit_tick) begin
                    if (r_bcnt == '0) begin
                        w_state_nxt = S_GAP;
                        w_dout_nxt  = 1'b0;
                        w_bcnt_nxt  = BCNT_W'(GAP_BITS - 1);
                    end else begin
                        w_dout_en_nxt = 1'b1;
                        w_dout_nxt    = r_shift[DATA_W-1];
                        w_shift_nxt   = r_shift << 1;
                        w_bcnt_nxt    = r_bcnt - BCNT_W'(1);
                    end
                end
            end

            S_GAP: begin
                w_dout_nxt = 1'b0;
                if (w_bit_tick) begin
                    if (r_bcnt == '0) begin
                        w_state_nxt      = S_IDLE;
                        w_frame_done_nxt = 1'b1;
                    end else begin
                        w_bcnt_nxt = r_bcnt - BCNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_dout_nxt  = 1'b0;
            end
        endcase

        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    assign tx.tx_ready  = r_ready;
    assign o_dout       = r_dout;
    assign o_dout_en    = r_dout_en;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

endmodule
